// File: rtl/ofm_tx_arb.sv
// Packet-granular 2:1 arbiter that shares one txc/txd AXI-Stream pair between two MM2S DMA channels.
// A granted channel owns the outputs from its first control beat through its last data beat.
module ofm_tx_arb #(
  parameter int C_FIXED_PRIO = 0
) (
  input  logic        mm2s_clk,
  input  logic        mm2s_resetn,
  input  logic [31:0] s0_txc_tdata,
  input  logic [3:0]  s0_txc_tkeep,
  input  logic        s0_txc_tvalid,
  input  logic        s0_txc_tlast,
  output logic        s0_txc_tready,
  input  logic [63:0] s0_txd_tdata,
  input  logic [7:0]  s0_txd_tkeep,
  input  logic        s0_txd_tvalid,
  input  logic        s0_txd_tlast,
  output logic        s0_txd_tready,
  input  logic [31:0] s1_txc_tdata,
  input  logic [3:0]  s1_txc_tkeep,
  input  logic        s1_txc_tvalid,
  input  logic        s1_txc_tlast,
  output logic        s1_txc_tready,
  input  logic [63:0] s1_txd_tdata,
  input  logic [7:0]  s1_txd_tkeep,
  input  logic        s1_txd_tvalid,
  input  logic        s1_txd_tlast,
  output logic        s1_txd_tready,
  output logic [31:0] txc_tdata,
  output logic [3:0]  txc_tkeep,
  output logic        txc_tvalid,
  output logic        txc_tlast,
  input  logic        txc_tready,
  output logic [63:0] txd_tdata,
  output logic [7:0]  txd_tkeep,
  output logic        txd_tvalid,
  output logic        txd_tlast,
  input  logic        txd_tready,
  output logic [15:0] pkt_cnt0,
  output logic [15:0] pkt_cnt1,
  output logic [3:0]  arb_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CTRL = 2'b01,
    DATA = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;
  logic        g_txc_tvalid, g_txd_tvalid;
  logic        c_rdy, d_rdy;

  // Payload always follows the registered grant, so idle outputs stay X-free.
  assign txc_tdata    = grant_q ? s1_txc_tdata  : s0_txc_tdata;
  assign txc_tkeep    = grant_q ? s1_txc_tkeep  : s0_txc_tkeep;
  assign txc_tlast    = grant_q ? s1_txc_tlast  : s0_txc_tlast;
  assign txd_tdata    = grant_q ? s1_txd_tdata  : s0_txd_tdata;
  assign txd_tkeep    = grant_q ? s1_txd_tkeep  : s0_txd_tkeep;
  assign txd_tlast    = grant_q ? s1_txd_tlast  : s0_txd_tlast;
  assign g_txc_tvalid = grant_q ? s1_txc_tvalid : s0_txc_tvalid;
  assign g_txd_tvalid = grant_q ? s1_txd_tvalid : s0_txd_tvalid;

  assign s0_txc_tready = c_rdy & ~grant_q;
  assign s1_txc_tready = c_rdy &  grant_q;
  assign s0_txd_tready = d_rdy & ~grant_q;
  assign s1_txd_tready = d_rdy &  grant_q;

  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;
  assign arb_dbg  = {grant_q, state_q, rr_ptr_q};

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    txc_tvalid = 1'b0;
    txd_tvalid = 1'b0;
    c_rdy      = 1'b0;
    d_rdy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (s0_txc_tvalid || s1_txc_tvalid) begin
          state_d = CTRL;
          if (s0_txc_tvalid && s1_txc_tvalid)
            grant_d = (C_FIXED_PRIO != 0) ? 1'b0 : rr_ptr_q;
          else
            grant_d = s1_txc_tvalid;
        end
      end
      CTRL: begin
        txc_tvalid = g_txc_tvalid;
        c_rdy      = txc_tready;
        if (g_txc_tvalid && txc_tready && txc_tlast)
          state_d = DATA;
      end
      DATA: begin
        txd_tvalid = g_txd_tvalid;
        d_rdy      = txd_tready;
        if (g_txd_tvalid && txd_tready && txd_tlast) begin
          state_d  = IDLE;
          rr_ptr_d = ~grant_q;
          if (grant_q) cnt1_d = cnt1_q + 16'd1;
          else         cnt0_d = cnt0_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
    if (!mm2s_resetn) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
      cnt0_q   <= 16'd0;
      cnt1_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

endmodule

// File: tb/tb_ofm_tx_arb.sv
// Directed bench for ofm_tx_arb: a round-robin instance (dut_a) and a fixed-priority
// instance (dut_b) share the same stimulus.
module tb_ofm_tx_arb;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] s0_txc_tdata, s1_txc_tdata;
  logic [3:0]  s0_txc_tkeep, s1_txc_tkeep;
  logic        s0_txc_tvalid, s0_txc_tlast, s1_txc_tvalid, s1_txc_tlast;
  logic [63:0] s0_txd_tdata, s1_txd_tdata;
  logic [7:0]  s0_txd_tkeep, s1_txd_tkeep;
  logic        s0_txd_tvalid, s0_txd_tlast, s1_txd_tvalid, s1_txd_tlast;
  logic        txc_tready, txd_tready;

  logic        a_s0c_rdy, a_s0d_rdy, a_s1c_rdy, a_s1d_rdy;
  logic [31:0] a_txc_tdata;
  logic [3:0]  a_txc_tkeep;
  logic        a_txc_tvalid, a_txc_tlast;
  logic [63:0] a_txd_tdata;
  logic [7:0]  a_txd_tkeep;
  logic        a_txd_tvalid, a_txd_tlast;
  logic [15:0] a_cnt0, a_cnt1;
  logic [3:0]  a_dbg;

  logic        b_s0c_rdy, b_s0d_rdy, b_s1c_rdy, b_s1d_rdy;
  logic [31:0] b_txc_tdata;
  logic [3:0]  b_txc_tkeep;
  logic        b_txc_tvalid, b_txc_tlast;
  logic [63:0] b_txd_tdata;
  logic [7:0]  b_txd_tkeep;
  logic        b_txd_tvalid, b_txd_tlast;
  logic [15:0] b_cnt0, b_cnt1;
  logic [3:0]  b_dbg;

  int nvec = 0;
  int nerr = 0;

  logic [63:0] t1d [3];
  logic [63:0] t4d [4];

  always #5 clk = ~clk;

  ofm_tx_arb #(.C_FIXED_PRIO(0)) dut_a (
    .mm2s_clk(clk), .mm2s_resetn(rstn),
    .s0_txc_tdata(s0_txc_tdata), .s0_txc_tkeep(s0_txc_tkeep), .s0_txc_tvalid(s0_txc_tvalid),
    .s0_txc_tlast(s0_txc_tlast), .s0_txc_tready(a_s0c_rdy),
    .s0_txd_tdata(s0_txd_tdata), .s0_txd_tkeep(s0_txd_tkeep), .s0_txd_tvalid(s0_txd_tvalid),
    .s0_txd_tlast(s0_txd_tlast), .s0_txd_tready(a_s0d_rdy),
    .s1_txc_tdata(s1_txc_tdata), .s1_txc_tkeep(s1_txc_tkeep), .s1_txc_tvalid(s1_txc_tvalid),
    .s1_txc_tlast(s1_txc_tlast), .s1_txc_tready(a_s1c_rdy),
    .s1_txd_tdata(s1_txd_tdata), .s1_txd_tkeep(s1_txd_tkeep), .s1_txd_tvalid(s1_txd_tvalid),
    .s1_txd_tlast(s1_txd_tlast), .s1_txd_tready(a_s1d_rdy),
    .txc_tdata(a_txc_tdata), .txc_tkeep(a_txc_tkeep), .txc_tvalid(a_txc_tvalid),
    .txc_tlast(a_txc_tlast), .txc_tready(txc_tready),
    .txd_tdata(a_txd_tdata), .txd_tkeep(a_txd_tkeep), .txd_tvalid(a_txd_tvalid),
    .txd_tlast(a_txd_tlast), .txd_tready(txd_tready),
    .pkt_cnt0(a_cnt0), .pkt_cnt1(a_cnt1), .arb_dbg(a_dbg)
  );

  ofm_tx_arb #(.C_FIXED_PRIO(1)) dut_b (
    .mm2s_clk(clk), .mm2s_resetn(rstn),
    .s0_txc_tdata(s0_txc_tdata), .s0_txc_tkeep(s0_txc_tkeep), .s0_txc_tvalid(s0_txc_tvalid),
    .s0_txc_tlast(s0_txc_tlast), .s0_txc_tready(b_s0c_rdy),
    .s0_txd_tdata(s0_txd_tdata), .s0_txd_tkeep(s0_txd_tkeep), .s0_txd_tvalid(s0_txd_tvalid),
    .s0_txd_tlast(s0_txd_tlast), .s0_txd_tready(b_s0d_rdy),
    .s1_txc_tdata(s1_txc_tdata), .s1_txc_tkeep(s1_txc_tkeep), .s1_txc_tvalid(s1_txc_tvalid),
    .s1_txc_tlast(s1_txc_tlast), .s1_txc_tready(b_s1c_rdy),
    .s1_txd_tdata(s1_txd_tdata), .s1_txd_tkeep(s1_txd_tkeep), .s1_txd_tvalid(s1_txd_tvalid),
    .s1_txd_tlast(s1_txd_tlast), .s1_txd_tready(b_s1d_rdy),
    .txc_tdata(b_txc_tdata), .txc_tkeep(b_txc_tkeep), .txc_tvalid(b_txc_tvalid),
    .txc_tlast(b_txc_tlast), .txc_tready(txc_tready),
    .txd_tdata(b_txd_tdata), .txd_tkeep(b_txd_tkeep), .txd_tvalid(b_txd_tvalid),
    .txd_tlast(b_txd_tlast), .txd_tready(txd_tready),
    .pkt_cnt0(b_cnt0), .pkt_cnt1(b_cnt1), .arb_dbg(b_dbg)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drv_c(input int ch, input logic v, input logic [31:0] d, input logic l);
    if (ch == 0) begin
      s0_txc_tvalid = v; s0_txc_tdata = d; s0_txc_tlast = l;
    end else begin
      s1_txc_tvalid = v; s1_txc_tdata = d; s1_txc_tlast = l;
    end
  endtask

  task automatic drv_d(input int ch, input logic v, input logic [63:0] d, input logic l);
    if (ch == 0) begin
      s0_txd_tvalid = v; s0_txd_tdata = d; s0_txd_tlast = l;
    end else begin
      s1_txd_tvalid = v; s1_txd_tdata = d; s1_txd_tlast = l;
    end
  endtask

  // One-beat control + one-beat data packet from IDLE with both readies high.
  task automatic run_pkt(input int ch, input logic [31:0] cw, input logic [63:0] dw);
    drv_c(ch, 1'b1, cw, 1'b1);
    smp(); chk("pkt_idle_state", a_dbg[2:1], 2'b00);
    cyc();
    smp(); chk("pkt_grant", a_dbg[3], ch); chk("pkt_txc_data", a_txc_tdata, cw);
    cyc();
    drv_c(ch, 1'b0, 32'h0, 1'b0);
    drv_d(ch, 1'b1, dw, 1'b1);
    smp(); chk("pkt_txd_data", a_txd_tdata, dw); chk("pkt_data_state", a_dbg[2:1], 2'b10);
    cyc();
    drv_d(ch, 1'b0, 64'h0, 1'b0);
  endtask

  initial begin
    int idx, t;
    logic hs;
    t1d[0] = 64'h0101_0202_0303_0404; t1d[1] = 64'hA5A5_5A5A_F00F_0FF0; t1d[2] = 64'hDEAD_BEEF_CAFE_F00D;
    t4d[0] = 64'h4000_0000_0000_0001; t4d[1] = 64'h4000_0000_0000_0002;
    t4d[2] = 64'h4000_0000_0000_0003; t4d[3] = 64'h4000_0000_0000_0004;
    rstn = 1'b0; txc_tready = 1'b0; txd_tready = 1'b0;
    s0_txc_tkeep = 4'hF; s1_txc_tkeep = 4'hF; s0_txd_tkeep = 8'hFF; s1_txd_tkeep = 8'hFF;
    drv_c(0, 1'b0, 32'h0, 1'b0); drv_c(1, 1'b0, 32'h0, 1'b0);
    drv_d(0, 1'b0, 64'h0, 1'b0); drv_d(1, 1'b0, 64'h0, 1'b0);

    // Reset values
    repeat (2) cyc();
    smp();
    chk("rst_rdy", {a_s0c_rdy, a_s0d_rdy, a_s1c_rdy, a_s1d_rdy}, 4'h0);
    chk("rst_valid", {a_txc_tvalid, a_txd_tvalid}, 2'b00);
    chk("rst_cnt", {a_cnt0, a_cnt1}, 32'h0);
    chk("rst_dbg", a_dbg, 4'h0);

    // Test 1: ch0 only, 2-beat control, 3-beat data
    cyc();
    rstn = 1'b1; txc_tready = 1'b1; txd_tready = 1'b1;
    drv_c(0, 1'b1, 32'h11, 1'b0);
    smp();
    chk("t1_idle_dbg", a_dbg, 4'b0000);
    chk("t1_idle_rdy", a_s0c_rdy, 1'b0);
    chk("t1_idle_vld", a_txc_tvalid, 1'b0);
    cyc();
    smp();
    chk("t1_c0_vld", a_txc_tvalid, 1'b1);
    chk("t1_c0_data", a_txc_tdata, 32'h11);
    chk("t1_c0_last", a_txc_tlast, 1'b0);
    chk("t1_c0_keep", a_txc_tkeep, 4'hF);
    chk("t1_c0_rdy", {a_s0c_rdy, a_s1c_rdy, a_s1d_rdy, a_txd_tvalid}, 4'b1000);
    chk("t1_c0_dbg", a_dbg, 4'b0010);
    cyc();
    drv_c(0, 1'b1, 32'h22, 1'b1);
    smp();
    chk("t1_c1_data", a_txc_tdata, 32'h22);
    chk("t1_c1_last", a_txc_tlast, 1'b1);
    chk("t1_c1_dbg", a_dbg, 4'b0010);
    cyc();
    drv_c(0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drv_d(0, 1'b1, t1d[i], (i == 2));
      smp();
      chk("t1_d_data", a_txd_tdata, t1d[i]);
      chk("t1_d_last", a_txd_tlast, (i == 2));
      chk("t1_d_keep", a_txd_tkeep, 8'hFF);
      chk("t1_d_vld_rdy", {a_txd_tvalid, a_s0d_rdy, a_s0c_rdy, a_s1c_rdy, a_s1d_rdy}, 5'b11000);
      chk("t1_d_dbg", a_dbg, 4'b0100);
      cyc();
    end
    drv_d(0, 1'b0, 64'h0, 1'b0);
    smp();
    chk("t1_end_dbg", a_dbg, 4'b0001);
    chk("t1_cnt0", a_cnt0, 16'd1);
    chk("t1_cnt1", a_cnt1, 16'd0);

    // Tests 2/3: both channels request continuously; dut_a round-robin, dut_b fixed
    #1 rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    drv_c(0, 1'b1, 32'hA0, 1'b1); drv_c(1, 1'b1, 32'hB1, 1'b1);
    drv_d(0, 1'b1, 64'hA0A0_A0A0_A0A0_A0A0, 1'b1); drv_d(1, 1'b1, 64'hB1B1_B1B1_B1B1_B1B1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("t2_idle", {a_dbg[2:1], b_dbg[2:1]}, 4'b0000);
      cyc();
      smp();
      chk("t2_rr_grant", a_dbg[3], k % 2);
      chk("t3_fix_grant", b_dbg[3], 1'b0);
      chk("t2_txc", a_txc_tdata, (k % 2) ? 32'hB1 : 32'hA0);
      chk("t3_txc", b_txc_tdata, 32'hA0);
      chk("t3_s1_rdy", b_s1c_rdy, 1'b0);
      cyc();
      smp();
      chk("t2_txd", a_txd_tdata, (k % 2) ? 64'hB1B1_B1B1_B1B1_B1B1 : 64'hA0A0_A0A0_A0A0_A0A0);
      chk("t3_txd", b_txd_tdata, 64'hA0A0_A0A0_A0A0_A0A0);
      cyc();
    end
    drv_c(0, 1'b0, 32'h0, 1'b0);
    smp();
    chk("t2_cnt", {a_cnt0, a_cnt1}, {16'd2, 16'd2});
    chk("t3_cnt", {b_cnt0, b_cnt1}, {16'd4, 16'd0});
    cyc();
    smp();
    chk("t3_ch1_grant", {b_dbg[3], b_s1c_rdy, a_dbg[3]}, 3'b111);
    cyc();
    smp();
    chk("t3_ch1_data", b_txd_tdata, 64'hB1B1_B1B1_B1B1_B1B1);
    cyc();
    drv_c(1, 1'b0, 32'h0, 1'b0); drv_d(0, 1'b0, 64'h0, 1'b0); drv_d(1, 1'b0, 64'h0, 1'b0);
    smp();
    chk("t3_cnt_end", {b_cnt0, b_cnt1}, {16'd4, 16'd1});
    chk("t2_cnt_end", a_cnt1, 16'd3);

    // Test 4: txd backpressure 1,0,1,0 with ch1 requesting mid-DATA
    cyc();
    drv_c(0, 1'b1, 32'hC0, 1'b1);
    smp(); cyc();
    smp(); chk("t4_grant", a_dbg[3], 1'b0);
    cyc();
    drv_c(0, 1'b0, 32'h0, 1'b0);
    idx = 0; t = 0;
    while (idx < 4 && t < 20) begin
      txd_tready = (t % 2 == 0);
      drv_d(0, 1'b1, t4d[idx], (idx == 3));
      if (t == 1) drv_c(1, 1'b1, 32'hD1, 1'b1);
      smp();
      chk("t4_rdy_follow", a_s0d_rdy, txd_tready);
      chk("t4_state", a_dbg[2:1], 2'b10);
      chk("t4_s1_wait", a_s1c_rdy, 1'b0);
      hs = a_txd_tvalid && txd_tready;
      if (hs) chk("t4_beat", a_txd_tdata, t4d[idx]);
      cyc();
      if (hs) idx++;
      t++;
    end
    chk("t4_beats", idx, 4);
    txd_tready = 1'b1;
    drv_d(0, 1'b0, 64'h0, 1'b0);
    smp();
    chk("t4_idle", {a_dbg[2:1], a_s1c_rdy}, 3'b000);
    cyc();
    smp();
    chk("t4_ch1_grant", a_dbg[3], 1'b1);
    chk("t4_ch1_txc", a_txc_tdata, 32'hD1);
    cyc();
    drv_c(1, 1'b0, 32'h0, 1'b0);
    drv_d(1, 1'b1, 64'hE1, 1'b1);
    smp(); chk("t4_ch1_txd", a_txd_tdata, 64'hE1);
    cyc();
    drv_d(1, 1'b0, 64'h0, 1'b0);
    smp();
    chk("t4_cnt", {a_cnt0, a_cnt1}, {16'd3, 16'd4});

    // Test 5: ch1 counter wrap
    force dut_a.cnt1_q = 16'hFFFF;
    #1 release dut_a.cnt1_q;
    #1 chk("t5_preload", a_cnt1, 16'hFFFF);
    cyc();
    run_pkt(1, 32'h55, 64'h5555);
    smp();
    chk("t5_wrap", a_cnt1, 16'h0000);
    chk("t5_cnt0", a_cnt0, 16'd3);

    // Test 6: asynchronous reset mid-DATA
    cyc();
    drv_c(0, 1'b1, 32'h66, 1'b1);
    smp(); cyc();
    smp(); cyc();
    drv_c(0, 1'b0, 32'h0, 1'b0);
    drv_d(0, 1'b1, 64'h77, 1'b0);
    smp();
    chk("t6_in_data", {a_s0d_rdy, a_txd_tvalid}, 2'b11);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_rdy", {a_s0c_rdy, a_s0d_rdy, a_s1c_rdy, a_s1d_rdy}, 4'h0);
    chk("t6_rst_vld", {a_txc_tvalid, a_txd_tvalid}, 2'b00);
    chk("t6_rst_cnt", {a_cnt0, a_cnt1, b_cnt0, b_cnt1}, 64'h0);
    chk("t6_rst_dbg", a_dbg, 4'h0);
    drv_d(0, 1'b0, 64'h0, 1'b0);
    cyc(); cyc();
    rstn = 1'b1;
    run_pkt(1, 32'h88, 64'h99);
    smp();
    chk("t6_cnt", {a_cnt0, a_cnt1}, {16'd0, 16'd1});
    chk("t6_dbg", a_dbg, 4'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
